// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: operation strobe, operand fields, two read ports and the status flags.
// The master drives operations and read addresses; the slave returns read data and flags.
interface reg_bank_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: an operation is taken on a rising edge where we=1 and busy=0;
  // while busy=1 the strobe is ignored and the master must hold or re-issue it.
  logic             we;
  logic [2:0]       op;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             zero;
  logic             carry;
  logic             busy;

  modport master (
    output we, op, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, zero, carry, busy
  );

  modport slave (
    input  we, op, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, zero, carry, busy
  );
endinterface

// File: rtl/reg_bank.sv
// Small register bank with single-entry ALU ops, a two-cycle SWAP and two combinational read ports.
// Optional macro REG_BANK_BYPASS_EN forwards the value being written to a matching read port.
module reg_bank #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank_if.slave  bus,
  output logic       o_dbg_state
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_SWAP = 3'b111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWAP2 = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_temp;
  logic [AW-1:0]    r_partner;
  logic             r_zero;
  logic             r_carry;

  logic             w_accept;
  logic [WIDTH-1:0] w_old;
  logic [AW-1:0]    w_partner;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_addr;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_flag_upd;
  logic             w_carry_new;
  logic             w_zero_new;
  logic             w_temp_ld;

  assign w_accept   = bus.we && (r_state == S_IDLE);
  assign w_old      = r_mem[bus.waddr];
  assign w_partner  = bus.wdata[AW-1:0];
  assign w_zero_new = (w_wr_data == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && bus.op == OP_SWAP) w_next_state = S_SWAP2;
      S_SWAP2: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy    = 1'b0;
    o_dbg_state = r_state;
    if (r_state == S_SWAP2) bus.busy = 1'b1;
  end

  // Single write port: the second SWAP cycle owns it, otherwise the accepted op does.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_addr   = bus.waddr;
    w_wr_data   = '0;
    w_flag_upd  = 1'b0;
    w_carry_new = r_carry;
    w_temp_ld   = 1'b0;
    if (r_state == S_SWAP2) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_partner;
      w_wr_data = r_temp;
    end else if (w_accept) begin
      case (bus.op)
        OP_LOAD: begin
          w_wr_en     = 1'b1;
          w_wr_data   = bus.wdata;
          w_flag_upd  = 1'b1;
          w_carry_new = 1'b0;
        end
        OP_INC: begin
          w_wr_en     = 1'b1;
          w_wr_data   = w_old + WIDTH'(1);
          w_flag_upd  = 1'b1;
          w_carry_new = &w_old;
        end
        OP_DEC: begin
          w_wr_en     = 1'b1;
          w_wr_data   = w_old - WIDTH'(1);
          w_flag_upd  = 1'b1;
          w_carry_new = ~|w_old;
        end
        OP_SHL: begin
          w_wr_en     = 1'b1;
          w_wr_data   = {w_old[WIDTH-2:0], 1'b0};
          w_flag_upd  = 1'b1;
          w_carry_new = w_old[WIDTH-1];
        end
        OP_SHR: begin
          w_wr_en     = 1'b1;
          w_wr_data   = {1'b0, w_old[WIDTH-1:1]};
          w_flag_upd  = 1'b1;
          w_carry_new = w_old[0];
        end
        OP_CLR: begin
          w_wr_en     = 1'b1;
          w_wr_data   = '0;
          w_flag_upd  = 1'b1;
          w_carry_new = 1'b0;
        end
        OP_SWAP: begin
          // First half: target takes the partner value, old target parks in temp.
          w_wr_en   = 1'b1;
          w_wr_data = r_mem[w_partner];
          w_temp_ld = 1'b1;
        end
        OP_NOP: begin
          w_wr_en = 1'b0;
        end
        default: begin
          w_wr_en = 1'b0;
        end
      endcase
    end
  end

  // Storage, temp and flags; reset drops any half-finished SWAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_temp    <= '0;
      r_partner <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
    end else begin
      if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
      if (w_temp_ld) begin
        r_temp    <= w_old;
        r_partner <= w_partner;
      end
      if (w_flag_upd) begin
        r_zero  <= w_zero_new;
        r_carry <= w_carry_new;
      end
    end
  end

  assign bus.zero  = r_zero;
  assign bus.carry = r_carry;

`ifdef REG_BANK_BYPASS_EN
  assign bus.rdata_a = (w_wr_en && bus.raddr_a == w_wr_addr) ? w_wr_data : r_mem[bus.raddr_a];
  assign bus.rdata_b = (w_wr_en && bus.raddr_b == w_wr_addr) ? w_wr_data : r_mem[bus.raddr_b];
`else
  assign bus.rdata_a = r_mem[bus.raddr_a];
  assign bus.rdata_b = r_mem[bus.raddr_b];
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (WIDTH=4, DEPTH=4): vector table for single-cycle ops,
// hand-written sequences for SWAP, reset during SWAP and same-cycle read-during-write.
module tb_reg_bank;
  localparam int W = 4;
  localparam int D = 4;

  logic clk;
  logic reset;
  logic dbg_state;

  int total;
  int bad;

  reg_bank_if #(.WIDTH(W), .DEPTH(D)) bus ();

  reg_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [1:0] addr;
    logic [3:0] data;
    logic [3:0] exp_val;
    logic       exp_z;
    logic       exp_c;
  } vec_t;

  vec_t vecs[14];

  // Scoreboard entries are {entry value, zero, carry}.
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [1:0] addr, input logic [3:0] data);
    @(negedge clk);
    bus.we      = 1'b1;
    bus.op      = op;
    bus.waddr   = addr;
    bus.wdata   = data;
    bus.raddr_a = addr;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic sb_compare(input string name);
    logic [W+1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got output expected nothing queued", name);
    end else begin
      e = exp_q.pop_front();
      total--;
      check(name, {bus.rdata_a, bus.zero, bus.carry}, e);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [1:0] addr,
                        input logic [3:0] data, input logic [3:0] ev, input logic ez, input logic ec);
    exp_q.push_back({ev, ez, ec});
    drive_op(op, addr, data);
    sb_compare(name);
  endtask

  task automatic read_a(input logic [1:0] addr, output logic [3:0] val);
    bus.raddr_a = addr;
    #1;
    val = bus.rdata_a;
  endtask

  initial begin
    logic [3:0] v;
    logic [3:0] exp_mem [4];
    logic [3:0] bypass_exp;

    total = 0;
    bad   = 0;

    vecs[0]  = '{"load_e2_f",  3'b001, 2'd2, 4'hF, 4'hF, 1'b0, 1'b0};
    vecs[1]  = '{"inc_e2_wrap", 3'b010, 2'd2, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[2]  = '{"nop_e2",     3'b000, 2'd2, 4'h5, 4'h0, 1'b1, 1'b1};
    vecs[3]  = '{"clr_e1",     3'b110, 2'd1, 4'h0, 4'h0, 1'b1, 1'b0};
    vecs[4]  = '{"dec_e1_wrap", 3'b011, 2'd1, 4'h0, 4'hF, 1'b0, 1'b1};
    vecs[5]  = '{"shr_e1",     3'b101, 2'd1, 4'h0, 4'h7, 1'b0, 1'b1};
    vecs[6]  = '{"shl_e1",     3'b100, 2'd1, 4'h0, 4'hE, 1'b0, 1'b0};
    vecs[7]  = '{"load_e0_3",  3'b001, 2'd0, 4'h3, 4'h3, 1'b0, 1'b0};
    vecs[8]  = '{"load_e3_a",  3'b001, 2'd3, 4'hA, 4'hA, 1'b0, 1'b0};
    vecs[9]  = '{"shl_e3_msb", 3'b100, 2'd3, 4'h0, 4'h4, 1'b0, 1'b1};
    vecs[10] = '{"shr_e0_lsb", 3'b101, 2'd0, 4'h0, 4'h1, 1'b0, 1'b1};
    vecs[11] = '{"dec_e0_zero", 3'b011, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0};
    vecs[12] = '{"inc_e0",     3'b010, 2'd0, 4'h0, 4'h1, 1'b0, 1'b0};
    vecs[13] = '{"shr_e0_z",   3'b101, 2'd0, 4'h0, 4'h0, 1'b1, 1'b1};

    bus.we = 1'b0; bus.op = 3'b000; bus.waddr = '0; bus.wdata = '0;
    bus.raddr_a = '0; bus.raddr_b = '0;
    reset = 1'b1;
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_zero", bus.zero, 1'b0);
    check("reset_carry", bus.carry, 1'b0);
    check("reset_state", dbg_state, 1'b0);
    for (int i = 0; i < D; i++) begin
      read_a(i[1:0], v);
      check($sformatf("reset_entry%0d", i), v, 4'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle ops
    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].data,
             vecs[i].exp_val, vecs[i].exp_z, vecs[i].exp_c);

    exp_mem[0] = 4'h0; exp_mem[1] = 4'hE; exp_mem[2] = 4'h0; exp_mem[3] = 4'h4;
    for (int i = 0; i < D; i++) begin
      read_a(i[1:0], v);
      check($sformatf("hold_entry%0d", i), v, exp_mem[i]);
    end

    // SWAP entry0/entry3 with a LOAD attempted while busy
    run_op("pre_load_e0", 3'b001, 2'd0, 4'h3, 4'h3, 1'b0, 1'b0);
    run_op("pre_load_e3", 3'b001, 2'd3, 4'hA, 4'hA, 1'b0, 1'b0);
    run_op("pre_dec_e2",  3'b011, 2'd2, 4'h0, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    bus.we = 1'b1; bus.op = 3'b111; bus.waddr = 2'd0; bus.wdata = 4'h3;
    @(posedge clk);
    #1;
    check("swap_busy_hi", bus.busy, 1'b1);
    check("swap_state", dbg_state, 1'b1);
    bus.op = 3'b001; bus.waddr = 2'd1; bus.wdata = 4'h5;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    check("swap_busy_lo", bus.busy, 1'b0);
    read_a(2'd0, v); check("swap_e0", v, 4'hA);
    read_a(2'd3, v); check("swap_e3", v, 4'h3);
    read_a(2'd1, v); check("busy_load_ignored", v, 4'hE);
    check("swap_zero_kept", bus.zero, 1'b0);
    check("swap_carry_kept", bus.carry, 1'b1);

    // Self-swap takes two cycles and changes nothing
    run_op("load_e1_5", 3'b001, 2'd1, 4'h5, 4'h5, 1'b0, 1'b0);
    @(negedge clk);
    bus.we = 1'b1; bus.op = 3'b111; bus.waddr = 2'd1; bus.wdata = 4'h1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    check("self_swap_busy_hi", bus.busy, 1'b1);
    @(posedge clk);
    #1;
    check("self_swap_busy_lo", bus.busy, 1'b0);
    read_a(2'd1, v); check("self_swap_e1", v, 4'h5);

    // Reset landing in the second SWAP cycle
    run_op("inc_e2_wrap2", 3'b010, 2'd2, 4'h0, 4'h0, 1'b1, 1'b1);
    @(negedge clk);
    bus.we = 1'b1; bus.op = 3'b111; bus.waddr = 2'd0; bus.wdata = 4'h3;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    check("rst_swap_busy_hi", bus.busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_zero", bus.zero, 1'b0);
    check("rst_carry", bus.carry, 1'b0);
    for (int i = 0; i < D; i++) begin
      read_a(i[1:0], v);
      check($sformatf("rst_entry%0d", i), v, 4'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst_load", 3'b001, 2'd3, 4'h6, 4'h6, 1'b0, 1'b0);

    // Read during write on both ports
`ifdef REG_BANK_BYPASS_EN
    bypass_exp = 4'h9;
`else
    bypass_exp = 4'h0;
`endif
    @(negedge clk);
    bus.we = 1'b1; bus.op = 3'b001; bus.waddr = 2'd2; bus.wdata = 4'h9;
    bus.raddr_a = 2'd2; bus.raddr_b = 2'd2;
    #1;
    check("rdw_port_a", bus.rdata_a, bypass_exp);
    check("rdw_port_b", bus.rdata_b, bypass_exp);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    check("rdw_after_a", bus.rdata_a, 4'h9);
    check("rdw_after_b", bus.rdata_b, 4'h9);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of each entry; legal range 2..16.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; power of two, at least 2. Address width AW = clog2(DEPTH).
REQ-003 SHALL have clk  input  1: clock; all state changes on the rising edge.
REQ-004 SHALL have reset  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have we  input  1: operation strobe; sampled only when busy=0.
REQ-006 SHALL have op  input  3: operation code, per REQ-011.
REQ-007 SHALL have waddr  input  AW: target entry.
REQ-008 SHALL have wdata  input  WIDTH: LOAD data; bits [AW-1:0] give the SWAP partner index.
REQ-009 SHALL have raddr_a / raddr_b  input  AW each: read addresses.
REQ-010 SHALL have these outputs:
- rdata_a / rdata_b  output  WIDTH each: combinational read data.
- zero  output  1: registered flag.
- carry  output  1: registered flag.
- busy  output  1: high while a SWAP occupies its second cycle.

Function
REQ-011 SHALL decode op as follows:
- 000 NOP
- 001 LOAD: entry = wdata
- 010 INC: entry + 1
- 011 DEC: entry - 1
- 100 SHL: shift left, fill 0
- 101 SHR: logical shift right, fill 0
- 110 CLR: entry = 0
- 111 SWAP
REQ-012 SHALL execute an op on the rising edge where we=1 and busy=0; while busy=1 it SHALL ignore we.
REQ-013 SHALL wrap INC and DEC modulo 2^WIDTH: INC of all-ones gives 0 with carry=1; DEC of 0 gives all-ones with carry=1 (borrow).
REQ-014 SHALL set carry to the shifted-out bit for SHL (old MSB) and SHR (old LSB); LOAD and CLR SHALL clear carry.
REQ-015 SHALL set zero = (result == 0) for ops 001-110; NOP and SWAP SHALL leave both flags unchanged.
REQ-016 SHALL use a two-state FSM for SWAP:
- IDLE -> SWAP2 on an accepted SWAP. That edge stores temp = entry[waddr], entry[waddr] = entry[p], where p = wdata[AW-1:0], and latches p.
- SWAP2 -> IDLE unconditionally. That edge writes entry[p] = temp.
REQ-017 SHALL drive busy=1 exactly while in SWAP2, i.e. for one cycle after the accepting edge.
REQ-018 SHALL treat SWAP with waddr == p as a two-cycle op that leaves contents unchanged.
REQ-019 SHALL drive rdata_a = entry[raddr_a] and rdata_b = entry[raddr_b] combinationally, with both ports independent and allowed to be equal.
REQ-020 SHALL modify only the addressed entry (or the two SWAP entries) per op; all others SHALL hold.

Reset
REQ-021 SHALL, on reset assertion and regardless of clock, clear all entries, zero, carry, busy and temp to 0 and set the FSM to IDLE.
REQ-022 SHALL abandon a SWAP interrupted by reset in SWAP2; after reset every entry SHALL be 0.
REQ-023 SHALL accept we on the first rising edge after reset deasserts.

Configuration
REQ-024 SHALL support macro REG_BANK_BYPASS_EN.
REQ-025 With REG_BANK_BYPASS_EN defined, a read port whose address matches an entry being written in the current cycle SHALL return the value to be written, for ops 001-110 and both SWAP writes.
REQ-026 Without REG_BANK_BYPASS_EN, read ports SHALL return stored contents only; the new value SHALL be visible the cycle after the edge.

Verification
All scenarios use WIDTH=4, DEPTH=4.
REQ-027 LOAD entry2=0xF, then INC entry2 -> entry2=0x0, zero=1, carry=1.
REQ-028 CLR entry1, then DEC entry1 -> entry1=0xF, zero=0, carry=1. Then SHR -> 0x7, carry=1. Then SHL -> 0xE, carry=0.
REQ-029 entry0=0x3, entry3=0xA; SWAP waddr=0, wdata=0x3 -> busy=1 for one cycle. A we=1 LOAD during busy is ignored. Afterwards entry0=0xA, entry3=0x3, flags unchanged.
REQ-030 SWAP waddr=1, wdata=0x1 with entry1=0x5 -> two cycles, entry1 stays 0x5.
REQ-031 Assert reset while busy=1 mid-SWAP -> all entries 0, zero=0, carry=0, busy=0 immediately. LOAD on the first edge after release succeeds.
REQ-032 LOAD entry2=0x9 with raddr_a=2 in the same cycle -> rdata_a=0x9 before the edge when REG_BANK_BYPASS_EN is defined, old value otherwise. rdata_b on raddr_b=2 matches rdata_a.
